reset_release_seq: RTL and testbench
====================================

# reset_release_seq

Reset sequencer that generates the design's synchronous active-high reset and clock-enable gating from the board-level active-low reset pin. It asserts its reset output immediately on the pin, then releases it a bounded 2–3 clocks after the pin deasserts. It also supports a software-requested reset pulse. It sits at the top of every clock domain, ahead of all blocks that sample `rst`/`ce`. It is the producer side of the "reset deasserts within [2:3] clocks" property.

## Interface
Parameters:
- `RELEASE_DLY`, default 2, the clock edge (counting from the first edge with the pin high) at which `rst_out` falls; legal values 2..3.
- `SW_RST_LEN`, default 4, the number of cycles `rst_out` is held in a software reset before release sequencing begins; legal values ≥1.
- `CNT_W`, default 8, the width of the release counter.

Ports:
- `clk`  in  1  single system clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `sw_rst_req`  in  1  synchronous software reset request, level-sampled.
- `ce_in`  in  1  raw clock enable from the upstream controller.
- `rst_out`  out  1  synchronous active-high reset to downstream logic.
- `ce_out`  out  1  gated clock enable, equal to `ce_in & ready`.
- `ready`  out  1  high while in `RUN`.
- `last_cause`  out  1  cause of the last reset: 0 = pin, 1 = software.
- `rel_cnt`  out  `CNT_W`  count of completed releases; wraps.

## Operation
States:
- **SYNC**: counts release edges with counter `cnt`, width 2.
- **RUN**: normal operation.
- **SWRST**: holds reset for `SW_RST_LEN` cycles with counter `hcnt`.

Transitions:
- `rst` low forces, asynchronously, state = SYNC, `cnt` = 0, `rst_out` = 1, `ready` = 0, `last_cause` = 0, `rel_cnt` = 0.
- In SYNC, each posedge increments `cnt`. On the edge where `cnt == RELEASE_DLY-1`:
  - state moves to RUN;
  - `rst_out` is registered 0;
  - `ready` is registered 1;
  - `rel_cnt` increments, wrapping to 0 after all-ones.
- In RUN, `sw_rst_req == 1` at a posedge moves to SWRST:
  - `rst_out` goes to 1 and `ready` to 0 on that edge;
  - `last_cause` is set to 1;
  - `hcnt` is set to 0.
- In SWRST, `hcnt` increments each edge. When `hcnt == SW_RST_LEN-1`, the state moves to SYNC with `cnt` = 0.
- `sw_rst_req` is ignored in SYNC and SWRST. A request held high across the return to RUN starts a new SWRST on the first RUN edge.
- `last_cause` is cleared only by the pin reset.
- `ce_out` is combinational: `ce_in & ready`. It is never high while `rst_out` is high.
- Pin assertion in any state, including mid-SWRST or mid-SYNC, aborts the state immediately and restarts from SYNC with `cnt` = 0.

## Timing
- Assertion latency from the pin to `rst_out` is 0 cycles (asynchronous).
- Pin release: with E1 as the first posedge sampling `rst` high, `rst_out` falls at edge E`RELEASE_DLY`. This gives 2 clocks for the default and 3 for `RELEASE_DLY` = 3. `rst_out` never stays high beyond edge E3.
- `ready` rises on the same edge `rst_out` falls.
- Software reset:
  - `rst_out` rises 1 edge after `sw_rst_req` is sampled.
  - Total reset duration is `SW_RST_LEN + RELEASE_DLY` cycles; the default is 6.
- There is no handshake on `sw_rst_req` and no acknowledge; the rising edge of `ready` is the completion indication.

## Configuration
- `RESET_RELEASE_SEQ_ASSERT_EN` defined:
  - compiles in a bound checker asserting `@(posedge clk) $rose(rst) |-> ##[1:RELEASE_DLY] !rst_out`;
  - `!ready |-> !ce_out`;
  - `$rose(sw_rst_req) && ready |=> rst_out`;
  - also compile-time checks that `RELEASE_DLY` is in 2..3 and `SW_RST_LEN` ≥ 1, with `$fatal` on violation.
- Macro undefined: no checker and no parameter checks. Functional RTL is identical in both cases.

## Structure
- Package `reset_release_seq_pkg`:
  - state enum `rstseq_state_e` (SYNC, RUN, SWRST);
  - cause enum `rst_cause_e` (CAUSE_PIN, CAUSE_SW);
  - localparams `RELEASE_DLY_MIN` = 2 and `RELEASE_DLY_MAX` = 3.
- One sub-module, `reset_release_seq_sva`, holds all assertions. It is instantiated via `bind` only under the macro. Core RTL is a single module.

## Test plan
- Hold `rst` = 0 for 20 ns, release at 20 ns (10 ns clock), `RELEASE_DLY` = 2 -> `rst_out` falls at the 2nd posedge after release; `ready` = 1; `rel_cnt` = 1; `last_cause` = 0.
- Same stimulus with `RELEASE_DLY` = 3 -> `rst_out` falls at the 3rd posedge. With `RESET_RELEASE_SEQ_ASSERT_EN` defined, the eventually/within check passes non-vacuously.
- In RUN, with `ce_in` = 1, pulse `sw_rst_req` for 1 cycle -> `rst_out` is high for exactly 6 cycles and `ce_out` = 0 throughout. `ready` returns, `last_cause` = 1, `rel_cnt` = 2.
- Assert `rst` = 0 mid-SWRST at `hcnt` = 2 -> outputs reset immediately. After release, `rst_out` falls after `RELEASE_DLY` edges; `last_cause` = 0 and `rel_cnt` = 1.
- Hold `sw_rst_req` = 1 continuously for 30 cycles -> back-to-back SWRST/SYNC cycles of 6, with `ready` high for 1 cycle between them. `rel_cnt` increments each release and wraps from 255 to 0 when forced near the limit.
- Toggle `ce_in` every cycle across a pin reset -> `ce_out` = 0 whenever `ready` = 0 and tracks `ce_in` exactly in RUN.

Source files
------------

// File: rtl/reset_release_seq_pkg.sv
// Shared types and limits for the reset release sequencer.
package reset_release_seq_pkg;

    // Sequencer states: release counting, normal run, software reset hold.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        RUN   = 2'd1,
        SWRST = 2'd2
    } rstseq_state_e;

    // Cause of the most recent reset.
    typedef enum logic {
        CAUSE_PIN = 1'b0,
        CAUSE_SW  = 1'b1
    } rst_cause_e;

    // Legal range of the release delay, in clock edges after the pin rises.
    localparam int RELEASE_DLY_MIN = 2;
    localparam int RELEASE_DLY_MAX = 3;

endpackage : reset_release_seq_pkg

// File: rtl/reset_release_seq_sva.sv
// Protocol checker for reset_release_seq. Bound into the sequencer only when
// RESET_RELEASE_SEQ_ASSERT_EN is defined; also rejects illegal parameters.
module reset_release_seq_sva
    import reset_release_seq_pkg::*;
#(
    parameter int RELEASE_DLY = 2,
    parameter int SW_RST_LEN  = 4
) (
    input logic clk,
    input logic rst,
    input logic sw_rst_req,
    input logic rst_out,
    input logic ready,
    input logic ce_out
);

    // Elaboration-time parameter range checks.
    if (RELEASE_DLY < RELEASE_DLY_MIN || RELEASE_DLY > RELEASE_DLY_MAX) begin : g_bad_release_dly
        $fatal(1, "reset_release_seq: RELEASE_DLY must be in 2..3");
    end
    if (SW_RST_LEN < 1) begin : g_bad_sw_rst_len
        $fatal(1, "reset_release_seq: SW_RST_LEN must be at least 1");
    end

    // Reset output must drop within RELEASE_DLY edges of the pin rising.
    a_release_bounded : assert property (
        @(posedge clk) $rose(rst) |-> ##[1:RELEASE_DLY] !rst_out
    );

    // Enable is gated off whenever the sequencer is not running.
    a_ce_gated : assert property (
        @(posedge clk) disable iff (!rst) !ready |-> !ce_out
    );

    // A fresh software request while running asserts reset on the next edge.
    a_sw_req_asserts : assert property (
        @(posedge clk) disable iff (!rst) ($rose(sw_rst_req) && ready) |=> rst_out
    );

endmodule : reset_release_seq_sva

// File: rtl/reset_release_seq.sv
// Reset release sequencer: turns the asynchronous active-low board pin into a
// synchronous active-high reset released a bounded RELEASE_DLY edges later,
// adds a software-requested reset of SW_RST_LEN cycles, and gates the clock
// enable with the run status.
// Optional: define RESET_RELEASE_SEQ_ASSERT_EN to bind reset_release_seq_sva.
module reset_release_seq
    import reset_release_seq_pkg::*;
#(
    parameter int RELEASE_DLY = 2,
    parameter int SW_RST_LEN  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_rst_req,
    input  logic             ce_in,
    output logic             rst_out,
    output logic             ce_out,
    output logic             ready,
    output logic             last_cause,
    output logic [CNT_W-1:0] rel_cnt
);

    localparam int               HCNT_W    = (SW_RST_LEN > 1) ? $clog2(SW_RST_LEN) : 1;
    localparam logic [1:0]        CNT_LAST  = 2'(RELEASE_DLY - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(SW_RST_LEN - 1);

    rstseq_state_e     state;
    logic [1:0]        cnt;
    logic [HCNT_W-1:0] hcnt;
    rst_cause_e        cause;

    // Sequencer FSM with release counter, hold counter and status registers.
    // NOTE: the pin clears every register asynchronously so rst_out rises with
    // zero latency; all state updates use non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SYNC;
            cnt     <= 2'd0;
            hcnt    <= '0;
            rst_out <= 1'b1;
            ready   <= 1'b0;
            cause   <= CAUSE_PIN;
            rel_cnt <= '0;
        end else begin
            case (state)
                SYNC: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == CNT_LAST) begin
                        state   <= RUN;
                        rst_out <= 1'b0;
                        ready   <= 1'b1;
                        rel_cnt <= rel_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        state   <= SWRST;
                        rst_out <= 1'b1;
                        ready   <= 1'b0;
                        cause   <= CAUSE_SW;
                        hcnt    <= '0;
                    end
                end
                SWRST: begin
                    if (hcnt == HCNT_LAST) begin
                        state <= SYNC;
                        cnt   <= 2'd0;
                    end else begin
                        hcnt <= hcnt + HCNT_W'(1);
                    end
                end
                default: begin
                    state   <= SYNC;
                    cnt     <= 2'd0;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Enable passes only while running; ready is low whenever rst_out is high.
    assign ce_out     = ce_in & ready;
    assign last_cause = cause;

endmodule : reset_release_seq

`ifdef RESET_RELEASE_SEQ_ASSERT_EN
bind reset_release_seq reset_release_seq_sva #(
    .RELEASE_DLY (RELEASE_DLY),
    .SW_RST_LEN  (SW_RST_LEN)
) u_reset_release_seq_sva (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .ready      (ready),
    .ce_out     (ce_out)
);
`else
// Checker not bound in this build.
`endif

// File: tb/tb_reset_release_seq.sv
// Directed bench for reset_release_seq: default instance plus a
// RELEASE_DLY = 3 instance sharing the same stimulus.
module tb_reset_release_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_rst_req;
    logic       ce_in;

    logic       rst_out,  ce_out,  ready,  last_cause;
    logic [7:0] rel_cnt;
    logic       rst_out3, ce_out3, ready3, last_cause3;
    logic [7:0] rel_cnt3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_release_seq u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .ce_in      (ce_in),
        .rst_out    (rst_out),
        .ce_out     (ce_out),
        .ready      (ready),
        .last_cause (last_cause),
        .rel_cnt    (rel_cnt)
    );

    reset_release_seq #(.RELEASE_DLY(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .ce_in      (ce_in),
        .rst_out    (rst_out3),
        .ce_out     (ce_out3),
        .ready      (ready3),
        .last_cause (last_cause3),
        .rel_cnt    (rel_cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         hi;
        int         hi3;
        int         leak;
        logic [11:0] exp_rdy;

        rst        = 1'b0;
        sw_rst_req = 1'b0;
        ce_in      = 1'b0;

        // Reset state while the pin is held low.
        @(negedge clk);
        check("rst_rst_out",    rst_out,    1'b1);
        check("rst_ready",      ready,      1'b0);
        check("rst_ce_out",     ce_out,     1'b0);
        check("rst_last_cause", last_cause, 1'b0);
        check("rst_rel_cnt",    rel_cnt,    8'd0);
        check("rst_rst_out3",   rst_out3,   1'b1);

        // Pin release at 20 ns.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("e1_rst_out",  rst_out,  1'b1);
        check("e1_ready",    ready,    1'b0);
        check("e1_rst_out3", rst_out3, 1'b1);
        @(negedge clk);
        check("e2_rst_out",    rst_out,    1'b0);
        check("e2_ready",      ready,      1'b1);
        check("e2_rel_cnt",    rel_cnt,    8'd1);
        check("e2_last_cause", last_cause, 1'b0);
        check("e2_rst_out3",   rst_out3,   1'b1);
        @(negedge clk);
        check("e3_rst_out3", rst_out3, 1'b0);
        check("e3_ready3",   ready3,   1'b1);

        // Enable passes straight through while running.
        ce_in = 1'b1;
        #1 check("run_ce_hi", ce_out, 1'b1);
        ce_in = 1'b0;
        #1 check("run_ce_lo", ce_out, 1'b0);

        // One-cycle software request with enable held high.
        @(negedge clk);
        sw_rst_req = 1'b1;
        ce_in      = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        hi   = 0;
        hi3  = 0;
        leak = 0;
        for (int k = 0; k < 12; k++) begin
            if (rst_out)  hi++;
            if (rst_out3) hi3++;
            if ((ce_out && rst_out) || (ce_out3 && rst_out3) || (ce_out && !ready)) leak++;
            @(negedge clk);
        end
        check("sw_rst_len",     hi,          6);
        check("sw_rst_len3",    hi3,         7);
        check("sw_ce_leak",     leak,        0);
        check("sw_ready",       ready,       1'b1);
        check("sw_ce_out",      ce_out,      1'b1);
        check("sw_last_cause",  last_cause,  1'b1);
        check("sw_rel_cnt",     rel_cnt,     8'd2);
        check("sw_rel_cnt3",    rel_cnt3,    8'd2);
        check("sw_last_cause3", last_cause3, 1'b1);

        // Pin reset in the middle of a software reset (hcnt == 2).
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out",    rst_out,    1'b1);
        check("mid_ready",      ready,      1'b0);
        check("mid_ce_out",     ce_out,     1'b0);
        check("mid_last_cause", last_cause, 1'b0);
        check("mid_rel_cnt",    rel_cnt,    8'd0);
        check("mid_rel_cnt3",   rel_cnt3,   8'd0);
        @(negedge clk);
        rst        = 1'b1;
        sw_rst_req = 1'b1;   // sampled only in SYNC, must be ignored
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("mid_e1_rst_out", rst_out, 1'b1);
        check("mid_e1_ready",   ready,   1'b0);
        @(negedge clk);
        check("mid_e2_rst_out",    rst_out,    1'b0);
        check("mid_e2_ready",      ready,      1'b1);
        check("mid_e2_rel_cnt",    rel_cnt,    8'd1);
        check("mid_e2_last_cause", last_cause, 1'b0);
        @(negedge clk);
        check("sync_req_ignored", ready,    1'b1);
        check("mid_e3_rst_out3",  rst_out3, 1'b0);
        check("mid_e3_rel_cnt3",  rel_cnt3, 8'd1);

        // Request held high: 6 cycles in reset, 1 cycle ready, repeating.
        sw_rst_req = 1'b1;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            check("held_rst_out", rst_out, (k % 7) != 6);
            check("held_ready",   ready,   (k % 7) == 6);
        end
        check("held_rel_cnt", rel_cnt, 8'd5);
        for (int k = 0; k < 1750; k++) @(negedge clk);
        check("wrap_rel_cnt_max", rel_cnt, 8'd255);
        check("wrap_ready_max",   ready,   1'b1);
        repeat (7) @(negedge clk);
        check("wrap_rel_cnt_zero", rel_cnt,    8'd0);
        check("wrap_ready_zero",   ready,      1'b1);
        check("wrap_last_cause",   last_cause, 1'b1);

        // Toggle ce_in every cycle across a two-cycle pin reset.
        sw_rst_req = 1'b0;
        exp_rdy    = 12'b1111_0000_1111;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ce_in = (i % 2) == 1;
            rst   = !(i == 4 || i == 5);
            #1;
            check("tog_ce_out", ce_out, ce_in & exp_rdy[i]);
            check("tog_ready",  ready,  exp_rdy[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_reset_release_seq
